vis_frame_scheduler: RTL and testbench

- Bus-domain controller that sequences visibility acquisition from the correlator.
- On command, it enables acquisition and aligns to a frame boundary. It then forwards exactly N complete visibility frames downstream, each prefixed by one header beat, and checks frame length.
- It sits between the correlator's bus_* visibility stream and the readout/host stream.

---
 rtl/vis_sched_pkg.sv | 19 +
 rtl/vis_frame_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_vis_frame_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vis_sched_pkg.sv
// rtl/vis_sched_pkg.sv - shared types and header layout for the visibility frame scheduler
package vis_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HEAD,
        ST_DATA,
        ST_DONE
    } sched_state_t;

    // Header beat: revis = {tag, seq}, imvis = {frame length, frames remaining}
    localparam int HDR_FIELD_W = 16;
    localparam int HDR_HI_LSB  = 16;
    localparam int HDR_LO_LSB  = 0;

    localparam logic [HDR_FIELD_W-1:0] MAGIC_DEFAULT = 16'hA5C3;

endpackage

// File: rtl/vis_frame_scheduler.sv
// rtl/vis_frame_scheduler.sv - gates N header-prefixed visibility frames from correlator to readout
module vis_frame_scheduler
    import vis_sched_pkg::*;
#(
    parameter int ACCUM     = 32,
    parameter int VIS_WORDS = 16,
    parameter int FBITS     = 16,
    parameter logic [HDR_FIELD_W-1:0] MAGIC = MAGIC_DEFAULT
) (
    input  logic             bus_clock,
    input  logic             bus_rst_n,
    input  logic             cmd_start_i,
    input  logic [FBITS-1:0] cmd_frames_i,
    input  logic             cmd_abort_i,
    output logic             acq_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             err_len_o,
    output logic [FBITS-1:0] frames_o,
    input  logic [ACCUM-1:0] s_revis_i,
    input  logic [ACCUM-1:0] s_imvis_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [ACCUM-1:0] m_revis_o,
    output logic [ACCUM-1:0] m_imvis_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i
);

    localparam logic [HDR_FIELD_W-1:0] LAST_BEAT = HDR_FIELD_W'(VIS_WORDS - 1);
    localparam logic [HDR_FIELD_W-1:0] VIS_LEN   = HDR_FIELD_W'(VIS_WORDS);
    localparam logic [HDR_FIELD_W-1:0] BEAT_MAX  = '1;
    localparam logic [HDR_FIELD_W-1:0] BEAT_ONE  = HDR_FIELD_W'(1);
    localparam logic [FBITS-1:0]       ONE_F     = FBITS'(1);

    sched_state_t state, state_nxt;

    logic [FBITS-1:0]       remaining;
    logic [FBITS-1:0]       seq;
    logic [FBITS-1:0]       frames;
    logic [HDR_FIELD_W-1:0] beat;
    logic                   mid;
    logic                   abort_pend;
    logic                   acq_en;
    logic                   aborted;
    logic                   err_len;

    logic start_ok;
    logic go_done;
    logic done_aborted;
    logic up_xfer;
    logic data_xfer;

    assign up_xfer   = s_valid_i && s_ready_o;
    assign data_xfer = (state == ST_DATA) && s_valid_i && m_ready_i;

    always_comb begin
        state_nxt    = state;
        s_ready_o    = 1'b0;
        m_valid_o    = 1'b0;
        m_last_o     = 1'b0;
        m_revis_o    = '0;
        m_imvis_o    = '0;
        start_ok     = 1'b0;
        go_done      = 1'b0;
        done_aborted = 1'b0;
        case (state)
            ST_IDLE: begin
                s_ready_o = 1'b1;
                if (cmd_start_i && (cmd_frames_i != '0)) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                // Drain any frame already in flight so the first forwarded beat starts a frame
                s_ready_o = mid;
                if (cmd_abort_i) begin
                    go_done      = 1'b1;
                    done_aborted = 1'b1;
                    state_nxt    = ST_DONE;
                end else if (!mid && s_valid_i) begin
                    state_nxt = ST_HEAD;
                end
            end
            ST_HEAD: begin
                m_valid_o = 1'b1;
                m_revis_o[HDR_HI_LSB +: HDR_FIELD_W] = MAGIC;
                m_revis_o[HDR_LO_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(seq);
                m_imvis_o[HDR_HI_LSB +: HDR_FIELD_W] = VIS_LEN;
                m_imvis_o[HDR_LO_LSB +: HDR_FIELD_W] = HDR_FIELD_W'(remaining);
                if (m_ready_i) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                m_valid_o = s_valid_i;
                m_last_o  = s_last_i;
                m_revis_o = s_revis_i;
                m_imvis_o = s_imvis_i;
                s_ready_o = m_ready_i;
                if (data_xfer && s_last_i) begin
                    // An abort landing on the final frame's last beat is just a normal finish
                    if (remaining == ONE_F) begin
                        go_done      = 1'b1;
                        done_aborted = abort_pend;
                        state_nxt    = ST_DONE;
                    end else if (abort_pend || cmd_abort_i) begin
                        go_done      = 1'b1;
                        done_aborted = 1'b1;
                        state_nxt    = ST_DONE;
                    end else begin
                        state_nxt = ST_HEAD;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clock or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state      <= ST_IDLE;
            remaining  <= '0;
            seq        <= '0;
            frames     <= '0;
            beat       <= '0;
            mid        <= 1'b0;
            abort_pend <= 1'b0;
            acq_en     <= 1'b0;
            aborted    <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state  <= state_nxt;
            acq_en <= (state == ST_ARM) || (state == ST_HEAD) || (state == ST_DATA);

            if (up_xfer) begin
                mid <= !s_last_i;
            end

            if (start_ok) begin
                remaining  <= cmd_frames_i;
                seq        <= '0;
                frames     <= '0;
                err_len    <= 1'b0;
                aborted    <= 1'b0;
                abort_pend <= 1'b0;
            end

            if (((state == ST_HEAD) || (state == ST_DATA)) && cmd_abort_i) begin
                abort_pend <= 1'b1;
            end

            if ((state == ST_HEAD) && m_ready_i) begin
                beat <= '0;
            end

            if (data_xfer) begin
                if (beat != BEAT_MAX) begin
                    beat <= beat + BEAT_ONE;
                end
                if (s_last_i) begin
                    if (beat != LAST_BEAT) begin
                        err_len <= 1'b1;
                    end
                    seq       <= seq + ONE_F;
                    frames    <= frames + ONE_F;
                    remaining <= remaining - ONE_F;
                end else if (beat == LAST_BEAT) begin
                    err_len <= 1'b1;
                end
            end

            if (go_done) begin
                aborted <= done_aborted;
            end
        end
    end

    assign acq_en_o  = acq_en;
    assign busy_o    = (state != ST_IDLE);
    assign done_o    = (state == ST_DONE);
    assign aborted_o = aborted;
    assign err_len_o = err_len;
    assign frames_o  = frames;

endmodule

// File: tb/tb_vis_frame_scheduler.sv
// tb/tb_vis_frame_scheduler.sv - directed self-checking bench for vis_frame_scheduler
module tb_vis_frame_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_start;
    logic [15:0] cmd_frames;
    logic        cmd_abort;
    logic        acq_en, busy, done, aborted, err_len;
    logic [15:0] frames;
    logic [31:0] s_revis, s_imvis, m_revis, m_imvis;
    logic        s_valid, s_last, s_ready;
    logic        m_valid, m_last, m_ready;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic        last;
    } beat_t;

    beat_t up_q[$];
    beat_t cap_q[$];
    beat_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int stall_err = 0;
    int rdy_err = 0;
    bit rdy_toggle = 1'b0;

    always #5 clk = ~clk;

    vis_frame_scheduler #(
        .ACCUM(32), .VIS_WORDS(4), .FBITS(16), .MAGIC(16'hA5C3)
    ) dut (
        .bus_clock(clk), .bus_rst_n(rst_n),
        .cmd_start_i(cmd_start), .cmd_frames_i(cmd_frames), .cmd_abort_i(cmd_abort),
        .acq_en_o(acq_en), .busy_o(busy), .done_o(done), .aborted_o(aborted),
        .err_len_o(err_len), .frames_o(frames),
        .s_revis_i(s_revis), .s_imvis_i(s_imvis), .s_valid_i(s_valid), .s_last_i(s_last),
        .s_ready_o(s_ready),
        .m_revis_o(m_revis), .m_imvis_o(m_imvis), .m_valid_o(m_valid), .m_last_o(m_last),
        .m_ready_i(m_ready)
    );

    // Upstream source, downstream sink and stream-discipline monitor
    initial begin
        bit    up_x;
        bit    prev_stall;
        beat_t prev;
        s_valid = 1'b0; s_revis = '0; s_imvis = '0; s_last = 1'b0; m_ready = 1'b1;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            up_x = s_valid && s_ready;
            if (rst_n) begin
                if (m_valid && m_ready) cap_q.push_back({m_revis, m_imvis, m_last});
                if (prev_stall && (!m_valid || ({m_revis, m_imvis, m_last} !== prev))) stall_err++;
                if (m_valid) begin
                    if (m_revis[31:16] == 16'hA5C3) begin
                        if (s_ready !== 1'b0) rdy_err++;
                    end else if (s_ready !== m_ready) begin
                        rdy_err++;
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev = {m_revis, m_imvis, m_last};
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            if (up_x && up_q.size() > 0) up_q.delete(0);
            if (up_q.size() > 0) begin
                s_valid = 1'b1; s_revis = up_q[0].re; s_imvis = up_q[0].im; s_last = up_q[0].last;
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            m_ready = rdy_toggle ? !m_ready : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        cmd_frames = n;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic exp_header(input int s, input int r);
        beat_t b;
        b.re = {16'hA5C3, 16'(s)};
        b.im = {16'h0004, 16'(r)};
        b.last = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic gen_frame(input int f, input int len, input bit to_up, input bit to_exp);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.re = 32'h1000_0000 + 32'(f * 256 + i);
            b.im = 32'h2000_0000 + 32'(f * 256 + i);
            b.last = (i == len - 1);
            if (to_up) up_q.push_back(b);
            if (to_exp) exp_q.push_back(b);
        end
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain_and_clear();
        for (int i = 0; i < 200 && up_q.size() > 0; i++) tick();
        tick();
        tick();
        up_q.delete();
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_start = 1'b0; cmd_frames = '0; cmd_abort = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (acq_en !== 1'b0) begin n_bad++; $display("FAIL reset_acq_en: got %b expected 0", acq_en); end
        n_cmp++; if ({done, aborted, err_len} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {done, aborted, err_len}); end
        n_cmp++; if (frames !== 16'd0) begin n_bad++; $display("FAIL reset_frames: got %0d expected 0", frames); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    endtask

    task automatic test_normal();
        bit seen;
        drain_and_clear();
        do_start(16'd2);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL normal_busy: got %b expected 1", busy); end
        exp_header(0, 2); gen_frame(0, 4, 1, 1);
        exp_header(1, 1); gen_frame(1, 4, 1, 1);
        gen_frame(2, 4, 1, 0);
        wait_done(seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL normal_done: got no done expected done pulse"); end
        n_cmp++; if (frames !== 16'd2) begin n_bad++; $display("FAIL normal_frames: got %0d expected 2", frames); end
        n_cmp++; if ({aborted, err_len} !== 2'b00) begin n_bad++; $display("FAIL normal_flags: got %b expected 00", {aborted, err_len}); end
        n_cmp++; if (acq_en !== 1'b1) begin n_bad++; $display("FAIL normal_acq_at_done: got %b expected 1", acq_en); end
        @(negedge clk);
        n_cmp++; if ({acq_en, busy, done} !== 3'b000) begin n_bad++; $display("FAIL normal_after_done: got %b expected 000", {acq_en, busy, done}); end
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL normal_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL normal_beat[%0d]: got %h/%h/%b expected %h/%h/%b", i, cap_q[i].re, cap_q[i].im, cap_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit seen;
        drain_and_clear();
        stall_err = 0;
        rdy_err = 0;
        rdy_toggle = 1'b1;
        do_start(16'd2);
        exp_header(0, 2); gen_frame(3, 4, 1, 1);
        exp_header(1, 1); gen_frame(4, 4, 1, 1);
        wait_done(seen);
        rdy_toggle = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_done: got no done expected done pulse"); end
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
        n_cmp++; if (rdy_err !== 0) begin n_bad++; $display("FAIL bp_s_ready: got %0d ready errors expected 0", rdy_err); end
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL bp_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bp_beat[%0d]: got %h/%h/%b expected %h/%h/%b", i, cap_q[i].re, cap_q[i].im, cap_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
        tick();
    endtask

    task automatic test_mid_start();
        bit seen;
        bit reached;
        drain_and_clear();
        gen_frame(5, 4, 1, 0);
        exp_header(0, 1); gen_frame(6, 4, 1, 1);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (up_q.size() <= 7) begin reached = 1'b1; break; end
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL mid_upstream: got %0d queued expected <= 7", up_q.size()); end
        tick();
        do_start(16'd1);
        wait_done(seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_done: got no done expected done pulse"); end
        n_cmp++; if ({frames, err_len} !== {16'd1, 1'b0}) begin n_bad++; $display("FAIL mid_status: got %0d/%b expected 1/0", frames, err_len); end
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL mid_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL mid_beat[%0d]: got %h/%h/%b expected %h/%h/%b", i, cap_q[i].re, cap_q[i].im, cap_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
        tick();
    endtask

    task automatic test_length();
        bit seen;
        drain_and_clear();
        do_start(16'd1);
        exp_header(0, 1); gen_frame(7, 3, 1, 1);
        wait_done(seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL short_done: got no done expected done pulse"); end
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL short_err: got %b expected 1", err_len); end
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL short_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL short_beat[%0d]: got %h/%h/%b expected %h/%h/%b", i, cap_q[i].re, cap_q[i].im, cap_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
        tick();
        drain_and_clear();
        do_start(16'd1);
        n_cmp++; if (err_len !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_start: got %b expected 0", err_len); end
        exp_header(0, 1); gen_frame(8, 6, 1, 1);
        wait_done(seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL long_done: got no done expected done pulse"); end
        n_cmp++; if (err_len !== 1'b1) begin n_bad++; $display("FAIL long_err: got %b expected 1", err_len); end
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL long_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL long_beat[%0d]: got %h/%h/%b expected %h/%h/%b", i, cap_q[i].re, cap_q[i].im, cap_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
        tick();
    endtask

    task automatic test_abort();
        bit seen;
        bit reached;
        drain_and_clear();
        do_start(16'd5);
        exp_header(0, 5); gen_frame(10, 4, 1, 1);
        for (int f = 11; f < 15; f++) gen_frame(f, 4, 1, 0);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cap_q.size() >= 2) begin reached = 1'b1; break; end
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL abort_reach_data: got %0d beats expected >= 2", cap_q.size()); end
        tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL abort_done: got no done expected done pulse"); end
        n_cmp++; if ({aborted, frames} !== {1'b1, 16'd1}) begin n_bad++; $display("FAIL abort_status: got %b/%0d expected 1/1", aborted, frames); end
        n_cmp++; if (cap_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL abort_count: got %0d expected %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL abort_beat[%0d]: got %h/%h/%b expected %h/%h/%b", i, cap_q[i].re, cap_q[i].im, cap_q[i].last, exp_q[i].re, exp_q[i].im, exp_q[i].last);
            end
        end
        tick();
    endtask

    task automatic test_abort_arm();
        drain_and_clear();
        do_start(16'd3);
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL arm_abort_done: got %b expected 1", done); end
        n_cmp++; if ({aborted, frames} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL arm_abort_status: got %b/%0d expected 1/0", aborted, frames); end
        n_cmp++; if (cap_q.size() !== 0) begin n_bad++; $display("FAIL arm_abort_output: got %0d beats expected 0", cap_q.size()); end
        tick();
        tick();
        do_start(16'd1);
        n_cmp++; if (aborted !== 1'b0) begin n_bad++; $display("FAIL aborted_clear_on_start: got %b expected 0", aborted); end
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        tick();
    endtask

    task automatic test_zero_start();
        drain_and_clear();
        do_start(16'd0);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_start_busy: got %b expected 0", busy); end
        tick();
        n_cmp++; if ({busy, acq_en} !== 2'b00) begin n_bad++; $display("FAIL zero_start_later: got %b expected 00", {busy, acq_en}); end
    endtask

    task automatic test_reset_mid_run();
        bit reached;
        drain_and_clear();
        do_start(16'd2);
        exp_header(0, 2); gen_frame(20, 4, 1, 1);
        gen_frame(21, 4, 1, 0);
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cap_q.size() >= 3) begin reached = 1'b1; break; end
        end
        n_cmp++; if (!reached) begin n_bad++; $display("FAIL rst_reach_data: got %0d beats expected >= 3", cap_q.size()); end
        n_cmp++; if ({m_valid, acq_en} !== 2'b11) begin n_bad++; $display("FAIL rst_pre_state: got %b expected 11", {m_valid, acq_en}); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({m_valid, acq_en, busy} !== 3'b000) begin n_bad++; $display("FAIL rst_async: got %b expected 000", {m_valid, acq_en, busy}); end
        n_cmp++; if ({s_ready, frames} !== {1'b1, 16'd0}) begin n_bad++; $display("FAIL rst_async_idle: got %b/%0d expected 1/0", s_ready, frames); end
        tick();
        up_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_start = 1'b0;
        cmd_frames = '0;
        cmd_abort = 1'b0;
        test_reset();
        test_normal();
        test_backpressure();
        test_mid_start();
        test_length();
        test_abort();
        test_abort_arm();
        test_zero_start();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
